// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle controller.
// Select encodings are enums so unused legal values (e.g. SB_FOUR) still document the datapath.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH,
        CL_JAL, CL_JALR, CL_LUI, CL_AUIPC, CL_ILL
    } cls_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
        ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR  = 4'd8, ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {PC_PLUS4 = 2'b00, PC_OLDIMM = 2'b01, PC_ALU = 2'b10} pc_src_t;
    typedef enum logic [1:0] {SA_RS1 = 2'b00, SA_OLDPC = 2'b01, SA_ZERO = 2'b10} src_a_t;
    typedef enum logic [1:0] {SB_RS2 = 2'b00, SB_IMM = 2'b01, SB_FOUR = 2'b10} src_b_t;
    typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10} wb_sel_t;
    typedef enum logic [1:0] {TC_NONE = 2'b00, TC_ILLEGAL = 2'b01, TC_BUS = 2'b10} trap_cause_t;

    function automatic cls_t classify(input logic [6:0] opc);
        case (opc)
            OPC_R:      return CL_R;
            OPC_I:      return CL_I;
            OPC_LOAD:   return CL_LOAD;
            OPC_STORE:  return CL_STORE;
            OPC_BRANCH: return CL_BRANCH;
            OPC_JAL:    return CL_JAL;
            OPC_JALR:   return CL_JALR;
            OPC_LUI:    return CL_LUI;
            OPC_AUIPC:  return CL_AUIPC;
            default:    return CL_ILL;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps instruction class + funct3 + funct7[5] to an ALU operation code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  cls_t       cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (cls)
            CL_R, CL_I: begin
                case (funct3)
                    // immediates reuse bit 30 as data, so only register ops may subtract
                    3'b000:  alu_op = (cls == CL_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            CL_BRANCH: begin
                case (funct3)
                    3'b100, 3'b101: alu_op = ALU_SLT;
                    3'b110, 3'b111: alu_op = ALU_SLTU;
                    default:        alu_op = ALU_SUB;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/exec/mem/wb over one shared memory port,
// with illegal-opcode and memory-timeout traps.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        oldpc_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [3:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state_dbg
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, next_state;
    cls_t       cls;
    logic [7:0] wait_cnt;
    logic [1:0] cause_q, next_cause;
    logic [3:0] dec_op;
    logic       mem_phase, expired, alu_en, taken;
    logic       unused_instr;

    assign cls          = classify(instr[6:0]);
    assign unused_instr = ^{instr[31], instr[29:15]};
    assign mem_phase    = (state == S_FETCH) || (state == S_MEM);
    // a same-cycle ready never reaches this term, so ready beats expiry
    assign expired      = mem_phase && !mem_ready && (wait_cnt == WAIT_LAST);
    assign alu_en       = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

    alu_decoder u_alu_dec (
        .cls      (cls),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_op   (dec_op)
    );

    always_comb begin
        case (instr[14:12])
            3'b000:         taken = alu_zero;
            3'b001:         taken = !alu_zero;
            3'b100, 3'b110: taken = alu_lt;
            3'b101, 3'b111: taken = !alu_lt;
            default:        taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            cause_q  <= TC_NONE;
        end else begin
            state    <= next_state;
            wait_cnt <= (mem_phase && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
            if (next_state == S_TRAP && state != S_TRAP)
                cause_q <= next_cause;
        end
    end

    always_comb begin
        next_state = state;
        next_cause = TC_NONE;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        oldpc_we   = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        reg_we     = 1'b0;
        wb_sel     = WB_ALU;
        retire     = 1'b0;
        case (state)
            S_IDLE: next_state = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    oldpc_we   = 1'b1;
                    pc_we      = 1'b1;
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = TC_BUS;
                end
            end
            S_DECODE: begin
                if (cls == CL_ILL) begin
                    next_state = S_TRAP;
                    next_cause = TC_ILLEGAL;
                end else begin
                    next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls)
                    CL_BRANCH: begin
                        pc_we      = taken;
                        pc_src     = taken ? PC_OLDIMM : PC_PLUS4;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: next_state = S_MEM;
                    CL_JAL: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_OLDIMM;
                        next_state = S_WB;
                    end
                    CL_JALR: begin
                        pc_we      = 1'b1;
                        pc_src     = PC_ALU;
                        next_state = S_WB;
                    end
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls == CL_STORE);
                if (mem_ready) begin
                    retire     = (cls == CL_STORE);
                    next_state = (cls == CL_STORE) ? S_FETCH : S_WB;
                end else if (expired) begin
                    next_state = S_TRAP;
                    next_cause = TC_BUS;
                end
            end
            S_WB: begin
                reg_we     = (instr[11:7] != 5'd0);
                retire     = 1'b1;
                next_state = S_FETCH;
                case (cls)
                    CL_LOAD:         wb_sel = WB_MEM;
                    CL_JAL, CL_JALR: wb_sel = WB_LINK;
                    default:         wb_sel = WB_ALU;
                endcase
            end
            S_TRAP: next_state = S_TRAP;
            default: next_state = S_IDLE;
        endcase
    end

    // ALU controls stay asserted through MEM/WB so the ALU result is held
    always_comb begin
        alu_src_a = SA_RS1;
        alu_src_b = SB_RS2;
        alu_op    = ALU_ADD;
        if (alu_en) begin
            alu_op = dec_op;
            case (cls)
                CL_I, CL_LOAD, CL_STORE, CL_JALR: alu_src_b = SB_IMM;
                CL_LUI: begin
                    alu_src_a = SA_ZERO;
                    alu_src_b = SB_IMM;
                end
                CL_AUIPC: begin
                    alu_src_a = SA_OLDPC;
                    alu_src_b = SB_IMM;
                end
                default: ;
            endcase
        end
    end

    assign trap       = (state == S_TRAP);
    assign trap_cause = trap ? cause_q : TC_NONE;
    assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: table of single instructions plus hand sequences for trap, timeout and reset.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, mem_ready = 1'b1;
    logic        mem_req, mem_we, addr_sel, ir_we, oldpc_we, pc_we, reg_we, retire, trap;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, wb_sel, trap_cause;
    logic [3:0]  alu_op;
    logic [2:0]  state_dbg;
    logic [25:0] outs;

    assign outs = {mem_req, mem_we, addr_sel, ir_we, oldpc_we, pc_we, pc_src, alu_src_a,
                   alu_src_b, alu_op, reg_we, wb_sel, retire, trap, trap_cause, state_dbg};

    multicycle_ctrl #(.MEM_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero), .alu_lt(alu_lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .oldpc_we(oldpc_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
        .wb_sel(wb_sel), .retire(retire), .trap(trap), .trap_cause(trap_cause),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        zero, lt;
        int          dly, lat;
        logic [3:0]  op;
        logic [1:0]  sa, sb;
        logic        pcwe;
        logic [1:0]  pcsrc;
        logic        rwe;
        logic [1:0]  wbs;
        logic [2:0]  last;
        logic        mem, we;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    initial begin
        int lat;
        //          instr         z     lt    dly lat op     sa     sb     pcwe  pcsrc  rwe   wbs    last  mem   we
        vecs[0]  = '{32'h00500093, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'h00000463, 1'b1, 1'b0, 0, 3, 4'd1, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0}; // beq taken
        vecs[2]  = '{32'h00001463, 1'b1, 1'b0, 0, 3, 4'd1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0}; // bne not taken
        vecs[3]  = '{32'h002081B3, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // add
        vecs[4]  = '{32'h402081B3, 1'b0, 1'b0, 0, 4, 4'd1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // sub
        vecs[5]  = '{32'h4020D1B3, 1'b0, 1'b0, 0, 4, 4'd7, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // sra
        vecs[6]  = '{32'h40000093, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // addi, bit30 set
        vecs[7]  = '{32'h0040A283, 1'b0, 1'b0, 3, 8, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b1, 2'b01, 3'd5, 1'b1, 1'b0}; // lw, 3 waits
        vecs[8]  = '{32'h0020A423, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 3'd4, 1'b1, 1'b1}; // sw
        vecs[9]  = '{32'h010000EF, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 2'b10, 3'd5, 1'b0, 1'b0}; // jal x1
        vecs[10] = '{32'h00008067, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 2'b10, 3'd5, 1'b0, 1'b0}; // jalr x0
        vecs[11] = '{32'h123452B7, 1'b0, 1'b0, 0, 4, 4'd0, 2'b10, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // lui
        vecs[12] = '{32'h00001317, 1'b0, 1'b0, 0, 4, 4'd0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // auipc
        vecs[13] = '{32'h0020C463, 1'b0, 1'b1, 0, 3, 4'd3, 2'b00, 2'b00, 1'b1, 2'b01, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0}; // blt taken
        vecs[14] = '{32'h0020F463, 1'b0, 1'b1, 0, 3, 4'd4, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 3'd3, 1'b0, 1'b0}; // bgeu not taken
        vecs[15] = '{32'h00000013, 1'b0, 1'b0, 0, 4, 4'd0, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 3'd5, 1'b0, 1'b0}; // nop: rd=x0
        vecs[16] = '{32'h002091B3, 1'b0, 1'b0, 0, 4, 4'd2, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 3'd5, 1'b0, 1'b0}; // sll

        #2;
        chk("reset_outs", 32'(outs), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_after_release", 32'(state_dbg), 32'd0);
        tick();
        chk("fetch_after_idle", 32'({state_dbg, mem_req, addr_sel}), 32'b001_1_0);

        for (int i = 0; i < NV; i++) begin
            lat = 0;
            instr    = vecs[i].instr;
            alu_zero = vecs[i].zero;
            alu_lt   = vecs[i].lt;
            for (int c = 1; c <= 12 && lat == 0; c++) begin
                mem_ready = !(c >= 4 && c < 4 + vecs[i].dly);
                @(negedge clk);
                if (c == 1)
                    chk($sformatf("v%0d_fetch", i),
                        32'({state_dbg, mem_req, addr_sel, ir_we, oldpc_we, pc_we, pc_src}),
                        32'({3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00}));
                if (c == 2)
                    chk($sformatf("v%0d_decode", i), 32'(state_dbg), 32'd2);
                if (c == 3) begin
                    chk($sformatf("v%0d_exec_state", i), 32'(state_dbg), 32'd3);
                    chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].op));
                    chk($sformatf("v%0d_src", i), 32'({alu_src_a, alu_src_b}),
                        32'({vecs[i].sa, vecs[i].sb}));
                    chk($sformatf("v%0d_pc_we", i), 32'(pc_we), 32'(vecs[i].pcwe));
                    if (vecs[i].pcwe)
                        chk($sformatf("v%0d_pc_src", i), 32'(pc_src), 32'(vecs[i].pcsrc));
                end
                if (vecs[i].mem && c >= 4 && c <= 4 + vecs[i].dly)
                    chk($sformatf("v%0d_mem_c%0d", i, c), 32'({mem_req, addr_sel, mem_we}),
                        32'({1'b1, 1'b1, vecs[i].we}));
                if (retire) begin
                    lat = c;
                    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
                    chk($sformatf("v%0d_last_state", i), 32'(state_dbg), 32'(vecs[i].last));
                    chk($sformatf("v%0d_reg_we", i), 32'(reg_we), 32'(vecs[i].rwe));
                    if (vecs[i].last == 3'd5)
                        chk($sformatf("v%0d_wb_sel", i), 32'(wb_sel), 32'(vecs[i].wbs));
                end
                tick();
            end
            if (lat == 0)
                chk($sformatf("v%0d_no_retire", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_back_to_fetch", i), 32'(state_dbg), 32'd1);
        end

        // illegal opcode: trap with cause 01, everything quiet for 20 cycles
        instr = 32'h0000007F;
        mem_ready = 1'b1;
        tick();
        chk("ill_decode", 32'(state_dbg), 32'd2);
        tick();
        for (int c = 0; c < 20; c++) begin
            mem_ready = c[0];
            @(negedge clk);
            chk($sformatf("ill_hold_c%0d", c),
                32'({trap, trap_cause, mem_req, mem_we, ir_we, oldpc_we, pc_we, reg_we, retire, state_dbg}),
                32'({1'b1, 2'b01, 7'b0, 3'd6}));
            tick();
        end

        // fetch never ready: trap after 8 cycles with cause 10
        do_reset();
        instr = 32'h00500093;
        mem_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("to_wait_c%0d", c), 32'({state_dbg, mem_req, trap}), 32'({3'd1, 1'b1, 1'b0}));
            tick();
        end
        @(negedge clk);
        chk("to_trap", 32'({trap, trap_cause, state_dbg, mem_req}), 32'({1'b1, 2'b10, 3'd6, 1'b0}));

        // ready arriving on the expiry cycle is accepted
        do_reset();
        mem_ready = 1'b0;
        for (int c = 1; c <= 7; c++) tick();
        mem_ready = 1'b1;
        @(negedge clk);
        chk("to_edge_accept", 32'({ir_we, pc_we, trap}), 32'({1'b1, 1'b1, 1'b0}));
        tick();
        chk("to_edge_decode", 32'({state_dbg, trap}), 32'({3'd2, 1'b0}));

        // async reset in the middle of a stalled store
        do_reset();
        instr = 32'h0020A423;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("sw_in_mem", 32'({state_dbg, mem_req, mem_we, addr_sel}), 32'({3'd4, 1'b1, 1'b1, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_idle", 32'(outs), 32'h0);
        tick();
        chk("post_reset_fetch", 32'({state_dbg, mem_req}), 32'({3'd1, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
